// File: rtl/pe_pkg.sv
// Shared types and constants for the PE convolution sequencer and address generator.
// Build option PE_CONV_RELU_EN: clamp negative captured results to zero.
package pe_pkg;

    localparam int A_DIM       = 4;
    localparam int F_DIM       = 3;
    localparam int O_DIM       = 2;
    localparam int MAC_PER_WIN = 9;

    localparam int S0_W = 4;
    localparam int S1_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_MAC  = 3'd2,
        ST_WAIT = 3'd3,
        ST_CAP  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // Value written into the result matrix at CAP.
    function automatic logic [7:0] cap_value(input logic [7:0] v);
`ifdef PE_CONV_RELU_EN
        return v[7] ? 8'h00 : v;
`else
        return v;
`endif
    endfunction

endpackage

// File: rtl/pe_addr_gen.sv
// Combinational (window, k) -> (input index, filter index) mapping for a 2x2 valid 3x3 convolution.
module pe_addr_gen
    import pe_pkg::*;
(
    input  logic [1:0]      w,
    input  logic [S1_W-1:0] k,
    output logic [S0_W-1:0] s0,
    output logic [S1_W-1:0] s1
);

    logic [1:0] r;
    logic [1:0] c;
    logic [1:0] row;
    logic [1:0] col;

    always_comb begin
        r = 2'd0;
        c = 2'd0;
        case (k)
            4'd0, 4'd1, 4'd2: r = 2'd0;
            4'd3, 4'd4, 4'd5: r = 2'd1;
            4'd6, 4'd7, 4'd8: r = 2'd2;
            default:          r = 2'd0;
        endcase
        case (k)
            4'd0, 4'd3, 4'd6: c = 2'd0;
            4'd1, 4'd4, 4'd7: c = 2'd1;
            4'd2, 4'd5, 4'd8: c = 2'd2;
            default:          c = 2'd0;
        endcase
    end

    // Window (i,j) is w = {i,j}; row*4+col is just the concatenation.
    assign row = {1'b0, w[1]} + r;
    assign col = {1'b0, w[0]} + c;
    assign s0  = {row, col};
    assign s1  = (k <= 4'd8) ? k : '0;

endmodule

// File: rtl/pe_conv_sequencer.sv
// Sequences one PE through a 2x2 valid convolution (4x4 input, 3x3 filter) and captures results.
// Build option PE_CONV_RELU_EN: negative results are stored as zero.
module pe_conv_sequencer
    import pe_pkg::*;
#(
    parameter int PE_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [7:0]      out,
    output logic [S0_W-1:0] s0,
    output logic [S1_W-1:0] s1,
    output logic            init,
    output logic            preset,
    output logic            busy,
    output logic            done,
    output logic [7:0]      c11,
    output logic [7:0]      c12,
    output logic [7:0]      c21,
    output logic [7:0]      c22,
    output logic [2:0]      dbg_state
);

    localparam logic [3:0] K_LAST    = 4'(MAC_PER_WIN - 1);
    localparam logic [2:0] WAIT_LAST = 3'(PE_LAT - 1);

    state_t           state_q, state_d;
    logic [1:0]       w_q, w_d;
    logic [3:0]       k_q, k_d;
    logic [2:0]       wait_q, wait_d;

    logic [S0_W-1:0]  s0_q, s0_nxt;
    logic [S1_W-1:0]  s1_q, s1_nxt;
    logic             init_q, preset_q, busy_q, done_q;
    logic [3:0][7:0]  c_q;

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        k_d     = k_q;
        wait_d  = wait_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_PRE;
                    w_d     = 2'd0;
                    k_d     = 4'd0;
                    wait_d  = 3'd0;
                end
            end
            ST_PRE:  state_d = ST_MAC;
            ST_MAC: begin
                if (k_q == K_LAST) begin
                    state_d = ST_WAIT;
                    wait_d  = 3'd0;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            ST_WAIT: begin
                if (wait_q == WAIT_LAST) state_d = ST_CAP;
                else                     wait_d  = wait_q + 3'd1;
            end
            ST_CAP: begin
                if (w_q == 2'd3) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MAC;
                    w_d     = w_q + 2'd1;
                    k_d     = 4'd0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Addresses are generated from next-state counters so the outputs can be registered
    // and still line up with the MAC cycle they belong to.
    pe_addr_gen u_addr_gen (
        .w  (w_d),
        .k  (k_d),
        .s0 (s0_nxt),
        .s1 (s1_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            w_q      <= '0;
            k_q      <= '0;
            wait_q   <= '0;
            s0_q     <= '0;
            s1_q     <= '0;
            init_q   <= 1'b0;
            preset_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            c_q      <= '0;
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            k_q      <= k_d;
            wait_q   <= wait_d;
            s0_q     <= (state_d == ST_MAC) ? s0_nxt : '0;
            s1_q     <= (state_d == ST_MAC) ? s1_nxt : '0;
            init_q   <= (state_d == ST_MAC) && (k_d == 4'd0);
            preset_q <= (state_d == ST_PRE);
            busy_q   <= (state_d != ST_IDLE);
            done_q   <= (state_d == ST_DONE);
            if (state_q == ST_CAP) c_q[w_q] <= cap_value(out);
        end
    end

    assign s0        = s0_q;
    assign s1        = s1_q;
    assign init      = init_q;
    assign preset    = preset_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign c11       = c_q[0];
    assign c12       = c_q[1];
    assign c21       = c_q[2];
    assign c22       = c_q[3];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pe_conv_sequencer.sv
// Bench for pe_conv_sequencer: job table applied through a cycle-accurate expectation queue.
module tb_pe_conv_sequencer;

    localparam int PE_LAT   = 1;
    localparam int P        = 10 + PE_LAT;
    localparam int DONE_CYC = 2 + 4 * P;
`ifdef PE_CONV_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] out;
    logic [3:0] s0, s1;
    logic       init, preset, busy, done;
    logic [7:0] c11, c12, c21, c22;
    logic [2:0] dbg_state;

    pe_conv_sequencer #(.PE_LAT(PE_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .out       (out),
        .s0        (s0),
        .s1        (s1),
        .init      (init),
        .preset    (preset),
        .busy      (busy),
        .done      (done),
        .c11       (c11),
        .c12       (c12),
        .c21       (c21),
        .c22       (c22),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][7:0] v;
        logic [3:0][7:0] exp_c;
        int              repulse;
        int              rst_at;
        bit              hold;
    } job_t;

    job_t            jobs[4];
    logic [43:0]     exp_q[$];
    logic [3:0][7:0] prev_c;
    logic [3:0][7:0] cur_exp;
    int              rst_g;
    bit              hold_g;
    int              n_pass;
    int              n_total;

    function automatic logic [3:0][7:0] pack4(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] c, input logic [7:0] d);
        logic [3:0][7:0] r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    // Expected outputs at cycle m after start was sampled (cycle 0), from the timing formulas.
    function automatic logic [43:0] model(input int m);
        logic [3:0]      s0e, s1e;
        logic            ie, pe, be, de;
        logic [3:0][7:0] ce;
        int              base, k;
        s0e = '0; s1e = '0; ie = 1'b0;
        if (rst_g >= 0 && m > rst_g) return '0;
        pe = (m == 1) || (hold_g && m == DONE_CYC + 2);
        be = (m >= 1 && m <= DONE_CYC) || (hold_g && m == DONE_CYC + 2);
        de = (m == DONE_CYC);
        for (int w = 0; w < 4; w++) begin
            base = 2 + P * w;
            if (m >= base && m <= base + 8) begin
                k   = m - base;
                s0e = 4'(((w / 2) + (k / 3)) * 4 + (w % 2) + (k % 3));
                s1e = 4'(k);
                ie  = (k == 0);
            end
            ce[w] = (m > base + 9 + PE_LAT) ? cur_exp[w] : prev_c[w];
        end
        return {s0e, s1e, ie, pe, be, de, ce[0], ce[1], ce[2], ce[3]};
    endfunction

    function automatic logic [43:0] actual();
        return {s0, s1, init, preset, busy, done, c11, c12, c21, c22};
    endfunction

    task automatic compare(input string name);
        logic [43:0] e;
        logic [43:0] g;
        g = actual();
        e = exp_q.pop_front();
        n_total++;
        if (g === e) n_pass++;
        else $display("FAIL %s: got s0/s1/init/pre/busy/done/c=%h expected %h", name, g, e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; out = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back('0);
        compare("reset");
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back('0);
        @(posedge clk);
        #1;
        compare("post_reset_idle");
        prev_c = '0;
    endtask

    task automatic run_job(input int idx);
        int max_n;
        bit is_cap;
        cur_exp = jobs[idx].exp_c;
        rst_g   = jobs[idx].rst_at;
        hold_g  = jobs[idx].hold;
        max_n   = hold_g ? DONE_CYC + 2 : DONE_CYC + 1;
        for (int n = 0; n < max_n; n++) begin
            @(negedge clk);
            start = (n == 0) || (n == jobs[idx].repulse) || (hold_g && n <= DONE_CYC + 1);
            rst   = (n == jobs[idx].rst_at);
            is_cap = 1'b0;
            for (int w = 0; w < 4; w++) begin
                if (n == 11 + PE_LAT + P * w) begin
                    out    = jobs[idx].v[w];
                    is_cap = 1'b1;
                end
            end
            if (!is_cap) out = 8'($urandom_range(0, 255));
            exp_q.push_back(model(n + 1));
            @(posedge clk);
            #1;
            compare($sformatf("job%0d_cyc%0d", idx, n + 1));
        end
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        prev_c = (jobs[idx].rst_at >= 0) ? '0 : cur_exp;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b0;
        start   = 1'b0;
        out     = 8'h00;
        prev_c  = '0;
        cur_exp = '0;
        rst_g   = -1;
        hold_g  = 1'b0;

        jobs[0].v       = pack4(8'h2A, 8'h13, 8'h7F, 8'h01);
        jobs[0].exp_c   = pack4(8'h2A, 8'h13, 8'h7F, 8'h01);
        jobs[0].repulse = -1; jobs[0].rst_at = -1; jobs[0].hold = 1'b0;

        jobs[1].v       = pack4(8'hF0, 8'h80, 8'h7F, 8'hFF);
        jobs[1].exp_c   = RELU ? pack4(8'h00, 8'h00, 8'h7F, 8'h00)
                               : pack4(8'hF0, 8'h80, 8'h7F, 8'hFF);
        jobs[1].repulse = 20; jobs[1].rst_at = -1; jobs[1].hold = 1'b0;

        jobs[2].v       = pack4(8'h11, 8'h22, 8'h33, 8'h44);
        jobs[2].exp_c   = pack4(8'h11, 8'h22, 8'h33, 8'h44);
        jobs[2].repulse = -1; jobs[2].rst_at = 2 + 2 * P + 3; jobs[2].hold = 1'b0;

        jobs[3].v       = pack4(8'h5A, 8'h25, 8'h3C, 8'h43);
        jobs[3].exp_c   = pack4(8'h5A, 8'h25, 8'h3C, 8'h43);
        jobs[3].repulse = -1; jobs[3].rst_at = -1; jobs[3].hold = 1'b1;

        do_reset();
        for (int j = 0; j < 4; j++) run_job(j);
        // The held start launched a second job; reset must abort it and clear the results.
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
